mult8_shift_add: RTL

- Sequential 8x8 unsigned shift-and-add multiplier that sits directly upstream of FADDER8 and drives it.
- Each iteration presents a partial-product high byte and the multiplicand to one FADDER8 instance, then registers FADDER8's sum and carry-out.
- Produces a 16-bit product after 8 iterations, with a start/busy/done handshake toward the datapath controller.
- The block is the team's first multi-cycle arithmetic unit built on the combinational adder library.

---
 rtl/mult8_shift_add.sv | 106 ++++++++++
 1 files changed

// File: rtl/mult8_shift_add.sv
// Sequential 8x8 unsigned shift-and-add multiplier driving one FADDER8 per iteration.
// FADDER8 is the combinational 8-bit ripple adder from the arithmetic library.

module FADDER8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CarryIn,
    output logic [7:0] Sum,
    output logic       CarryOut
);

    assign {CarryOut, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, CarryIn};

endmodule

module mult8_shift_add #(
    parameter int OP_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    generate
        if (OP_WIDTH != 8) begin : g_bad_width
            $error("mult8_shift_add: OP_WIDTH must be 8 (fixed by FADDER8)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  mcand;
    logic [7:0]  acc_hi;
    logic [7:0]  mq;
    logic [2:0]  cnt;
    logic [7:0]  s;
    logic        c;
    logic [7:0]  addend;

    assign addend = mq[0] ? mcand : 8'h00;

    FADDER8 u_add (
        .A        (acc_hi),
        .B        (addend),
        .CarryIn  (1'b0),
        .Sum      (s),
        .CarryOut (c)
    );

    // busy/done are registered alongside the state so they change on the same edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            mq      <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mq     <= b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    {acc_hi, mq} <= {c, s, mq[7:1]};
                    cnt          <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= {c, s, mq[7:1]};
                        state   <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
